hits_orbit_monitor: RTL

- Receiving end of the hit-generator output stream: consumes the per-bunch-crossing (BC) hit bit and the bunch-train mask bit, one of each per clock.
- Tracks BC position inside the orbit and accumulates per-orbit statistics: hit count, active-bunch count and longest run of consecutive hits.
- At each orbit boundary, publishes a result record to the HPS-side reader through a valid/ack handshake.
- Lets software measure the effective occupancy produced by the generator against the programmed occupancy.

---
 rtl/hits_orbit_monitor_if.sv | 24 ++
 rtl/hits_orbit_monitor.sv | 131 +++++++++++++
 2 files changed

// File: rtl/hits_orbit_monitor_if.sv
// Result-record channel between the orbit monitor (master) and the HPS-side reader (slave).
// The record is held until the reader acknowledges it with a one-cycle pulse.
interface hits_orbit_monitor_if #(
   parameter int unsigned CNT_W = 12,
   parameter int unsigned ORB_W = 16
);
   logic [CNT_W-1:0] orbit_hits;
   logic [CNT_W-1:0] orbit_active;
   logic [CNT_W-1:0] orbit_max_run;
   logic [ORB_W-1:0] orbit_num;
   logic             res_valid;
   logic             res_overrun;
   logic             res_ack;

   modport master (
      output orbit_hits, orbit_active, orbit_max_run, orbit_num, res_valid, res_overrun,
      input  res_ack
   );

   modport slave (
      input  orbit_hits, orbit_active, orbit_max_run, orbit_num, res_valid, res_overrun,
      output res_ack
   );
endinterface

// File: rtl/hits_orbit_monitor.sv
// Per-orbit hit statistics on the hit-generator output stream.
// Each completed orbit's record is published to the reader through a valid/ack handshake.
module hits_orbit_monitor #(
   parameter int unsigned BUNCH_POS = 3564,
   parameter int unsigned CNT_W     = 12,
   parameter int unsigned ORB_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             hit_in,
   input  logic             mask_in,
   output logic [CNT_W-1:0] bc_count,
   hits_orbit_monitor_if.master res
);

   localparam logic [CNT_W-1:0] LAST_BC = CNT_W'(BUNCH_POS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RUN
   } state_t;

   state_t state, state_nxt;

   logic             last;
   logic             accumulate;
   logic             publish;
   logic             ack_ok;
   logic [CNT_W-1:0] hit_acc, act_acc, run_cnt, max_run;
   logic [CNT_W-1:0] hit_sum, act_sum, run_inc, run_nxt, max_nxt;

   assign last   = (bc_count == LAST_BC);
   assign ack_ok = res.res_valid && res.res_ack;

   // Free-running so the BC index stays aligned with the mask generator sharing this reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bc_count <= '0;
      end else if (last) begin
         bc_count <= '0;
      end else begin
         bc_count <= bc_count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (en) state_nxt = last ? S_RUN : S_WAIT;
         S_WAIT: begin
            if (!en) begin
               state_nxt = S_IDLE;
            end else if (last) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN:  if (!en) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      accumulate = (state == S_RUN) && en;
      publish    = accumulate && last;
   end

   // Sums include the current BC so the published record covers the last BC of the orbit.
   always_comb begin
      hit_sum = hit_acc + CNT_W'(hit_in);
      act_sum = act_acc + CNT_W'(mask_in);
      run_inc = run_cnt + CNT_W'(1);
      run_nxt = hit_in ? run_inc : '0;
      max_nxt = (hit_in && (run_inc > max_run)) ? run_inc : max_run;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_acc <= '0;
         act_acc <= '0;
         run_cnt <= '0;
         max_run <= '0;
      end else if (publish || !accumulate) begin
         hit_acc <= '0;
         act_acc <= '0;
         run_cnt <= '0;
         max_run <= '0;
      end else begin
         hit_acc <= hit_sum;
         act_acc <= act_sum;
         run_cnt <= run_nxt;
         max_run <= max_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res.orbit_hits    <= '0;
         res.orbit_active  <= '0;
         res.orbit_max_run <= '0;
         res.orbit_num     <= '0;
         res.res_valid     <= 1'b0;
         res.res_overrun   <= 1'b0;
      end else if (publish) begin
         res.orbit_hits    <= hit_sum;
         res.orbit_active  <= act_sum;
         res.orbit_max_run <= max_nxt;
         res.orbit_num     <= res.orbit_num + ORB_W'(1);
         res.res_valid     <= 1'b1;
         // A coincident ack retires the old record, so only an unacked overwrite is an overrun.
         if (res.res_valid && !res.res_ack) begin
            res.res_overrun <= 1'b1;
         end else if (ack_ok) begin
            res.res_overrun <= 1'b0;
         end
      end else if (ack_ok) begin
         res.res_valid   <= 1'b0;
         res.res_overrun <= 1'b0;
      end
   end

endmodule
